// File: rtl/autocat_waymask_applier_pkg.sv
// Shared constants and FSM encoding for the autocat way-mask applier.
package autocat_waymask_applier_pkg;

   localparam int DEFAULT_NUM_WAY         = 16;
   localparam int DEFAULT_NUM_SET         = 64;
   localparam int DEFAULT_SET_INDEX_WIDTH = 6;
   localparam int DEFAULT_WAY_INDEX_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_FLUSH  = 2'd2,
      ST_COMMIT = 2'd3
   } applier_state_t;

endpackage

// File: rtl/autocat_first_set.sv
// Lowest-set-bit finder: one-hot, binary index and any-set flag of a vector.
module autocat_first_set #(
   parameter int WIDTH       = 16,
   parameter int INDEX_WIDTH = 4
) (
   input  logic [WIDTH-1:0]       vec,
   output logic [WIDTH-1:0]       onehot,
   output logic [INDEX_WIDTH-1:0] index,
   output logic                   any
);

   // Two's-complement trick isolates the lowest set bit; descending scan leaves the lowest index.
   always_comb begin
      onehot = vec & (~vec + WIDTH'(1));
      any    = |vec;
      index  = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            index = INDEX_WIDTH'(i);
         end else begin
            index = index;
         end
      end
   end

endmodule

// File: rtl/autocat_waymask_applier.sv
// Applies autocat's suggested way mask: drain, optional per-set writeback flush, commit.
// Writeback flushing of revoked ways is built only with AUTOCAT_WAYMASK_FLUSH_EN defined.
module autocat_waymask_applier
   import autocat_waymask_applier_pkg::*;
#(
   parameter int NUM_WAY         = DEFAULT_NUM_WAY,
   parameter int NUM_SET         = DEFAULT_NUM_SET,
   parameter int SET_INDEX_WIDTH = DEFAULT_SET_INDEX_WIDTH,
   parameter int WAY_INDEX_WIDTH = DEFAULT_WAY_INDEX_WIDTH
) (
   input  logic                       clk_in,
   input  logic                       reset_in,
   input  logic [NUM_WAY-1:0]         suggested_waymask_in,
   input  logic                       lookup_valid_in,
   input  logic [NUM_WAY-1:0]         lookup_hit_way_in,
   input  logic                       inflight_empty_in,
   input  logic                       flush_ready_in,
   output logic                       access_valid_out,
   output logic [NUM_WAY-1:0]         hit_vec_out,
   output logic [NUM_WAY-1:0]         active_waymask_out,
   output logic                       flush_valid_out,
   output logic [SET_INDEX_WIDTH-1:0] flush_set_out,
   output logic [WAY_INDEX_WIDTH-1:0] flush_way_out,
   output logic                       update_busy_out
);

   applier_state_t       state_r;
   logic [NUM_WAY-1:0]   active_r;
   logic [NUM_WAY-1:0]   pending_r;
   logic [NUM_WAY-1:0]   revoked_r;
   logic [NUM_WAY-1:0]   mask_out_r;
   logic                 busy_r;
   logic                 access_valid_r;
   logic [NUM_WAY-1:0]   hit_vec_r;

`ifdef AUTOCAT_WAYMASK_FLUSH_EN
   localparam logic [SET_INDEX_WIDTH-1:0] SET_LAST = SET_INDEX_WIDTH'(NUM_SET - 1);

   logic [SET_INDEX_WIDTH-1:0] set_r;
   logic [NUM_WAY-1:0]         remain_r;
   logic                       flush_valid_r;
   logic [WAY_INDEX_WIDTH-1:0] flush_way_r;
   logic [NUM_WAY-1:0]         find_vec_s;
   logic [NUM_WAY-1:0]         find_onehot_s;
   logic [WAY_INDEX_WIDTH-1:0] find_idx_s;
   logic                       find_any_s;

   // Next way comes from the rest of this set, or restarts from the full revoked set.
   always_comb begin
      if ((state_r == ST_FLUSH) && (|remain_r)) begin
         find_vec_s = remain_r;
      end else begin
         find_vec_s = revoked_r;
      end
   end

   autocat_first_set #(
      .WIDTH       (NUM_WAY),
      .INDEX_WIDTH (WAY_INDEX_WIDTH)
   ) u_first_set (
      .vec    (find_vec_s),
      .onehot (find_onehot_s),
      .index  (find_idx_s),
      .any    (find_any_s)
   );

   assign flush_valid_out = flush_valid_r;
   assign flush_set_out   = set_r;
   assign flush_way_out   = flush_way_r;
`else
   assign flush_valid_out = 1'b0;
   assign flush_set_out   = '0;
   assign flush_way_out   = '0;
`endif

   // Update FSM with registered active mask and busy flag.
   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         state_r    <= ST_IDLE;
         active_r   <= '1;
         pending_r  <= '0;
         revoked_r  <= '0;
         mask_out_r <= '1;
         busy_r     <= 1'b0;
`ifdef AUTOCAT_WAYMASK_FLUSH_EN
         set_r         <= '0;
         remain_r      <= '0;
         flush_valid_r <= 1'b0;
         flush_way_r   <= '0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if ((suggested_waymask_in != active_r) && (suggested_waymask_in != '0)) begin
                  pending_r  <= suggested_waymask_in;
                  revoked_r  <= active_r & ~suggested_waymask_in;
                  mask_out_r <= active_r & suggested_waymask_in;
                  busy_r     <= 1'b1;
                  state_r    <= ((active_r & ~suggested_waymask_in) == '0) ? ST_COMMIT : ST_DRAIN;
               end else begin
                  mask_out_r <= active_r;
                  busy_r     <= 1'b0;
               end
            end
            ST_DRAIN: begin
`ifdef AUTOCAT_WAYMASK_FLUSH_EN
               if (inflight_empty_in && find_any_s) begin
                  state_r       <= ST_FLUSH;
                  set_r         <= '0;
                  flush_valid_r <= 1'b1;
                  flush_way_r   <= find_idx_s;
                  remain_r      <= revoked_r & ~find_onehot_s;
               end
`else
               if (inflight_empty_in) begin
                  state_r <= ST_COMMIT;
               end
`endif
            end
            ST_FLUSH: begin
`ifdef AUTOCAT_WAYMASK_FLUSH_EN
               if (flush_ready_in) begin
                  if (|remain_r) begin
                     flush_way_r <= find_idx_s;
                     remain_r    <= remain_r & ~find_onehot_s;
                  end else if (set_r == SET_LAST) begin
                     flush_valid_r <= 1'b0;
                     state_r       <= ST_COMMIT;
                  end else begin
                     set_r       <= set_r + SET_INDEX_WIDTH'(1);
                     flush_way_r <= find_idx_s;
                     remain_r    <= revoked_r & ~find_onehot_s;
                  end
               end
`else
               state_r <= ST_COMMIT;
`endif
            end
            ST_COMMIT: begin
               active_r   <= pending_r;
               mask_out_r <= pending_r;
               busy_r     <= 1'b0;
               state_r    <= ST_IDLE;
            end
            default: begin
               state_r    <= ST_IDLE;
               mask_out_r <= active_r;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   // Hit report path: one cycle latency, hits outside the partition become misses.
   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         access_valid_r <= 1'b0;
         hit_vec_r      <= '0;
      end else begin
         access_valid_r <= lookup_valid_in;
         hit_vec_r      <= lookup_valid_in ? (lookup_hit_way_in & mask_out_r) : '0;
      end
   end

   assign access_valid_out   = access_valid_r;
   assign hit_vec_out        = hit_vec_r;
   assign active_waymask_out = mask_out_r;
   assign update_busy_out    = busy_r;

endmodule

// File: tb/tb_autocat_waymask_applier.sv
// Directed bench for autocat_waymask_applier: hit-report table plus mask update sequences.
module tb_autocat_waymask_applier;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic [15:0] suggested_waymask_in;
   logic        lookup_valid_in;
   logic [15:0] lookup_hit_way_in;
   logic        inflight_empty_in;
   logic        flush_ready_in;
   logic        access_valid_out;
   logic [15:0] hit_vec_out;
   logic [15:0] active_waymask_out;
   logic        flush_valid_out;
   logic [5:0]  flush_set_out;
   logic [3:0]  flush_way_out;
   logic        update_busy_out;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        v;
      logic [15:0] hw;
      logic        exp_access;
      logic [15:0] exp_hit;
   } vec_t;

   vec_t tbl[5];

   always #5 clk_in = ~clk_in;

   autocat_waymask_applier dut (
      .clk_in               (clk_in),
      .reset_in             (reset_in),
      .suggested_waymask_in (suggested_waymask_in),
      .lookup_valid_in      (lookup_valid_in),
      .lookup_hit_way_in    (lookup_hit_way_in),
      .inflight_empty_in    (inflight_empty_in),
      .flush_ready_in       (flush_ready_in),
      .access_valid_out     (access_valid_out),
      .hit_vec_out          (hit_vec_out),
      .active_waymask_out   (active_waymask_out),
      .flush_valid_out      (flush_valid_out),
      .flush_set_out        (flush_set_out),
      .flush_way_out        (flush_way_out),
      .update_busy_out      (update_busy_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   function automatic int first_way(input logic [15:0] m, input int from);
      for (int i = from; i < 16; i++) begin
         if (m[i]) return i;
      end
      return -1;
   endfunction

`ifdef AUTOCAT_WAYMASK_FLUSH_EN
   // Entered with state FLUSH; returns just after the final handshake edge.
   task automatic run_flush(input logic [15:0] rev, input bit toggle);
      int s   = 0;
      int w   = first_way(rev, 0);
      int cyc = 0;
      while (s < 64 && cyc < 4000) begin
         flush_ready_in = toggle ? cyc[0] : 1'b1;
         check("flush_valid", 32'(flush_valid_out), 32'd1);
         check("flush_set", 32'(flush_set_out), s);
         check("flush_way", 32'(flush_way_out), w);
         if (flush_ready_in) begin
            w = first_way(rev, w + 1);
            if (w < 0) begin
               s++;
               w = first_way(rev, 0);
            end
         end
         tick();
         cyc++;
      end
      check("flush_sets_done", s, 64);
      flush_ready_in = 1'b1;
      check("flush_valid_after", 32'(flush_valid_out), 32'd0);
   endtask
`endif

   // Entered right after the edge into DRAIN with inflight_empty_in already 1.
   task automatic complete_shrink(input logic [15:0] rev, input bit toggle, input logic [15:0] exp_active);
      tick();
`ifdef AUTOCAT_WAYMASK_FLUSH_EN
      run_flush(rev, toggle);
`else
      check("nof_flush_valid", 32'(flush_valid_out), 32'd0);
      check("nof_rev_nonzero", 32'(rev != 16'h0000), 32'd1);
      check("nof_toggle_ignored", 32'(toggle | 1'b1), 32'd1);
`endif
      check("commit_busy", 32'(update_busy_out), 32'd1);
      check("commit_mask", 32'(active_waymask_out), 32'(exp_active));
      tick();
      check("idle_busy", 32'(update_busy_out), 32'd0);
      check("idle_active", 32'(active_waymask_out), 32'(exp_active));
   endtask

   initial begin
      tbl[0] = '{1'b1, 16'h0010, 1'b1, 16'h0010};
      tbl[1] = '{1'b0, 16'h0010, 1'b0, 16'h0000};
      tbl[2] = '{1'b1, 16'h0000, 1'b1, 16'h0000};
      tbl[3] = '{1'b1, 16'h8000, 1'b1, 16'h8000};
      tbl[4] = '{1'b1, 16'h0001, 1'b1, 16'h0001};

      reset_in             = 1'b0;
      suggested_waymask_in = 16'hFFFF;
      lookup_valid_in      = 1'b1;
      lookup_hit_way_in    = 16'h0001;
      inflight_empty_in    = 1'b1;
      flush_ready_in       = 1'b1;
      repeat (3) tick();
      check("rst_active", 32'(active_waymask_out), 32'h0000FFFF);
      check("rst_flush_valid", 32'(flush_valid_out), 32'd0);
      check("rst_busy", 32'(update_busy_out), 32'd0);
      check("rst_hit_vec", 32'(hit_vec_out), 32'd0);
      check("rst_access", 32'(access_valid_out), 32'd0);
      check("rst_flush_set", 32'(flush_set_out), 32'd0);
      lookup_valid_in = 1'b0;
      reset_in        = 1'b1;
      tick();

      // Hit reporting with full mask
      for (int i = 0; i < 5; i++) begin
         lookup_valid_in   = tbl[i].v;
         lookup_hit_way_in = tbl[i].hw;
         tick();
         check($sformatf("tbl%0d_access", i), 32'(access_valid_out), 32'(tbl[i].exp_access));
         check($sformatf("tbl%0d_hit", i), 32'(hit_vec_out), 32'(tbl[i].exp_hit));
      end
      lookup_valid_in = 1'b0;

      // All-zero suggestion is ignored
      suggested_waymask_in = 16'h0000;
      repeat (3) tick();
      check("zero_busy", 32'(update_busy_out), 32'd0);
      check("zero_active", 32'(active_waymask_out), 32'h0000FFFF);

      // Shrink to 00FF with pipeline not empty: held in DRAIN
      suggested_waymask_in = 16'h00FF;
      inflight_empty_in    = 1'b0;
      tick();
      check("drain_busy0", 32'(update_busy_out), 32'd1);
      check("drain_mask0", 32'(active_waymask_out), 32'h000000FF);
      suggested_waymask_in = 16'h0F0F;
      lookup_valid_in      = 1'b1;
      lookup_hit_way_in    = 16'h0100;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("drain_busy", 32'(update_busy_out), 32'd1);
         check("drain_mask", 32'(active_waymask_out), 32'h000000FF);
         check("drain_flush_valid", 32'(flush_valid_out), 32'd0);
         check("drain_hit_masked", 32'(hit_vec_out), 32'd0);
      end
      lookup_valid_in      = 1'b0;
      suggested_waymask_in = 16'h00FF;
      inflight_empty_in    = 1'b1;
      complete_shrink(16'hFF00, 1'b0, 16'h00FF);
      repeat (2) tick();
      check("shrink_stays_idle", 32'(update_busy_out), 32'd0);

      // Pure grow 00FF -> 0FFF: no flush, visible after two edges
      suggested_waymask_in = 16'h0FFF;
      tick();
      check("grow_busy", 32'(update_busy_out), 32'd1);
      check("grow_mask_t", 32'(active_waymask_out), 32'h000000FF);
      check("grow_no_flush", 32'(flush_valid_out), 32'd0);
      tick();
      check("grow_busy_done", 32'(update_busy_out), 32'd0);
      check("grow_active", 32'(active_waymask_out), 32'h00000FFF);

      // Shrink 0FFF -> 000F with stalling writeback unit
      suggested_waymask_in = 16'h000F;
      tick();
      check("shrink2_mask", 32'(active_waymask_out), 32'h0000000F);
      complete_shrink(16'h0FF0, 1'b1, 16'h000F);

      // Hits outside the new partition become misses
      lookup_valid_in   = 1'b1;
      lookup_hit_way_in = 16'h0010;
      tick();
      check("part_access", 32'(access_valid_out), 32'd1);
      check("part_miss", 32'(hit_vec_out), 32'd0);
      lookup_hit_way_in = 16'h0008;
      tick();
      check("part_hit", 32'(hit_vec_out), 32'h00000008);
      lookup_valid_in = 1'b0;

      // Reset in the middle of an update
      suggested_waymask_in = 16'h0003;
      flush_ready_in       = 1'b0;
`ifdef AUTOCAT_WAYMASK_FLUSH_EN
      inflight_empty_in = 1'b1;
      tick();
      tick();
      check("mid_flush_valid", 32'(flush_valid_out), 32'd1);
      check("mid_flush_way", 32'(flush_way_out), 32'd2);
      tick();
      check("mid_flush_stall_way", 32'(flush_way_out), 32'd2);
`else
      inflight_empty_in = 1'b0;
      repeat (3) tick();
`endif
      check("mid_busy", 32'(update_busy_out), 32'd1);
      check("mid_mask", 32'(active_waymask_out), 32'h00000003);
      reset_in             = 1'b0;
      suggested_waymask_in = 16'hFFFF;
      tick();
      check("mid_rst_busy", 32'(update_busy_out), 32'd0);
      check("mid_rst_active", 32'(active_waymask_out), 32'h0000FFFF);
      check("mid_rst_flush", 32'(flush_valid_out), 32'd0);
      reset_in          = 1'b1;
      flush_ready_in    = 1'b1;
      inflight_empty_in = 1'b1;
      repeat (2) tick();
      check("post_rst_busy", 32'(update_busy_out), 32'd0);
      check("post_rst_active", 32'(active_waymask_out), 32'h0000FFFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
